ps2_key_decoder: RTL and testbench

//  Receives raw PS/2 keyboard frames, strips E0/F0 prefixes, and queues key events {e0,break,code} in a FWFT FIFO.

---
 rtl/ps2_key_decoder.sv | 198 +++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: frames raw PS/2 bits, folds E0/F0 prefixes into
// {e0,break,code} key events, queues them in a FWFT FIFO and tracks the held extended key.
module ps2_key_decoder #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd_en,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_e0,
  output logic       key_break,
  output logic [7:0] scanCode_E0,
  output logic       frame_err,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_E0   = 2'd1,
    S_F0   = 2'd2,
    S_E0F0 = 2'd3
  } pfx_t;

  // Odd parity holds when data bits plus the parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [8:0] d);
    return ^d;
  endfunction

  logic [2:0]    clk_sync_q, dat_sync_q;
  logic          fall_s, bit_s;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    shift_q, shift_d;
  logic [TW-1:0] to_q, to_d;
  logic [7:0]    byte_q, byte_d;
  logic          byte_vld_q, byte_vld_d;
  logic          frame_err_q, frame_err_d;
  pfx_t          state_q, state_d;
  logic          emit_s, emit_e0_s, emit_brk_s;
  logic [7:0]    sc_q, sc_d;
  logic [9:0]    mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic          empty_s, full_s, pop_s, push_s;
  logic          ovf_q, ovf_d;

  // Stage 1 samples the pins; stage 2 vs stage 3 compares old and new clock levels.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync_q <= 3'b000;
      dat_sync_q <= 3'b000;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[1:0], ps2_data};
    end
  end

  assign fall_s = clk_sync_q[2] & ~clk_sync_q[1];
  assign bit_s  = dat_sync_q[1];

  // Bit collection, frame check on the 11th edge, and stalled-frame timeout.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    to_d        = to_q;
    byte_d      = byte_q;
    byte_vld_d  = 1'b0;
    frame_err_d = 1'b0;
    if (fall_s) begin
      to_d = '0;
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = 4'd0;
        if (!shift_q[0] && odd_parity_ok(shift_q[9:1]) && bit_s) begin
          byte_d     = shift_q[8:1];
          byte_vld_d = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
      end else begin
        shift_d[bit_cnt_q] = bit_s;
        bit_cnt_d          = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q == 4'd0) begin
      to_d = '0;
    end else if (to_q == TW'(TIMEOUT)) begin
      bit_cnt_d = 4'd0;
      to_d      = '0;
    end else begin
      to_d = to_q + TW'(1);
    end
  end

  // Prefix tracking; a non-prefix byte produces one event and returns to IDLE.
  always_comb begin
    state_d    = state_q;
    emit_s     = 1'b0;
    emit_e0_s  = 1'b0;
    emit_brk_s = 1'b0;
    if (byte_vld_q) begin
      case (byte_q)
        8'hE0: begin
          case (state_q)
            S_IDLE:  state_d = S_E0;
            S_F0:    state_d = S_E0F0;
            default: state_d = state_q;
          endcase
        end
        8'hF0: begin
          case (state_q)
            S_IDLE:  state_d = S_F0;
            S_E0:    state_d = S_E0F0;
            default: state_d = state_q;
          endcase
        end
        default: begin
          emit_s     = 1'b1;
          emit_e0_s  = (state_q == S_E0) || (state_q == S_E0F0);
          emit_brk_s = (state_q == S_F0) || (state_q == S_E0F0);
          state_d    = S_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Held extended key follows every emitted event, whether or not the FIFO keeps it.
  always_comb begin
    sc_d = sc_q;
    if (emit_s && emit_e0_s && !emit_brk_s) begin
      sc_d = byte_q;
    end else if (emit_s && emit_e0_s && emit_brk_s && (byte_q == sc_q)) begin
      sc_d = 8'h00;
    end else begin
      sc_d = sc_q;
    end
  end

  assign empty_s = (wr_ptr_q == rd_ptr_q);
  assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_s   = rd_en & ~empty_s;
  assign push_s  = emit_s & (~full_s | pop_s);
  assign ovf_d   = emit_s & full_s & ~pop_s;

  // Receiver, prefix and held-key state registers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      bit_cnt_q   <= 4'd0;
      shift_q     <= 10'd0;
      to_q        <= '0;
      byte_q      <= 8'h00;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      state_q     <= S_IDLE;
      sc_q        <= 8'h00;
      ovf_q       <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      to_q        <= to_d;
      byte_q      <= byte_d;
      byte_vld_q  <= byte_vld_d;
      frame_err_q <= frame_err_d;
      state_q     <= state_d;
      sc_q        <= sc_d;
      ovf_q       <= ovf_d;
    end
  end

  // Event FIFO storage and pointers; the extra pointer bit separates full from empty.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 10'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q[AW-1:0]] <= {emit_e0_s, emit_brk_s, byte_q};
        wr_ptr_q                <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      end
      if (pop_s) rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  assign key_valid   = ~empty_s;
  assign key_e0      = mem_q[rd_ptr_q[AW-1:0]][9];
  assign key_break   = mem_q[rd_ptr_q[AW-1:0]][8];
  assign key_code    = mem_q[rd_ptr_q[AW-1:0]][7:0];
  assign scanCode_E0 = sc_q;
  assign frame_err   = frame_err_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: an event-level model (prefix flags plus expected-event
// queue) checked every cycle against the FIFO head, plus hand-computed literal checks.
module tb_ps2_key_decoder;
  localparam int DEPTH = 8;
  localparam int TO    = 300;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd_en = 1'b0;
  logic       key_valid, key_e0, key_break, frame_err, overflow;
  logic [7:0] key_code, scanCode_E0;

  ps2_key_decoder #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en),
    .key_valid(key_valid), .key_code(key_code), .key_e0(key_e0), .key_break(key_break),
    .scanCode_E0(scanCode_E0), .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [9:0] mq[$];
  bit m_e0 = 1'b0, m_brk = 1'b0;
  logic [7:0] m_sc = 8'h00;
  int exp_ferr = 0, exp_ovf = 0, seen_ferr = 0, seen_ovf = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Event-level model of one correctly framed byte.
  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) m_e0 = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      if (m_e0 && !m_brk) m_sc = b;
      else if (m_e0 && m_brk && b == m_sc) m_sc = 8'h00;
      if (mq.size() == DEPTH) exp_ovf++;
      else mq.push_back({m_e0, m_brk, b});
      m_e0 = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  // Per-cycle comparison of the FIFO head and pulse counting.
  always @(negedge clk) begin
    if (clrn) begin
      if (frame_err) seen_ferr++;
      if (overflow) seen_ovf++;
      if (key_valid) begin
        if (mq.size() == 0) chk("head_unexpected", {22'd0, key_e0, key_break, key_code}, 32'hFFFF);
        else chk("head", {22'd0, key_e0, key_break, key_code}, {22'd0, mq[0]});
        if (rd_en && mq.size() != 0) void'(mq.pop_front());
      end
    end
  end

  // One PS/2 bit: data set while clock high, 8 cycles low, 8 cycles high.
  // lat returns posedges from the falling edge until key_valid rises (-1 if not seen).
  task automatic drive_bit(input logic b, output int lat);
    logic prev;
    ps2_data = b;
    repeat (4) @(posedge clk);
    #1 ps2_clk = 1'b0;
    prev = key_valid;
    lat = -1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (lat < 0 && key_valid && !prev) lat = k;
    end
    ps2_clk = 1'b1;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, output int lat);
    logic [10:0] f;
    int l;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    if (bad_par) exp_ferr++;
    else model_byte(b);
    for (int i = 0; i < 11; i++) drive_bit(f[i], l);
    lat = l;
  endtask

  task automatic send(input logic [7:0] b);
    int l;
    send_frame(b, 1'b0, l);
  endtask

  task automatic send_partial(input logic [7:0] b, input int n);
    logic [10:0] f;
    int l;
    f = {1'b1, ~^b, b, 1'b0};
    for (int i = 0; i < n; i++) drive_bit(f[i], l);
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  task automatic drain(output int n);
    n = 0;
    while (key_valid && n < DEPTH + 4) begin
      pop_one();
      n++;
    end
    chk("drain_empty", {31'd0, key_valid}, 32'd0);
    chk("drain_model", mq.size(), 32'd0);
  endtask

  task automatic settle_check(input string tag);
    chk({tag, "_valid"}, {31'd0, key_valid}, {31'd0, mq.size() != 0});
    chk({tag, "_sc"}, {24'd0, scanCode_E0}, {24'd0, m_sc});
    chk({tag, "_ferr"}, seen_ferr, exp_ferr);
    chk({tag, "_ovf"}, seen_ovf, exp_ovf);
  endtask

  task automatic do_reset(input int cycles);
    clrn = 1'b0;
    mq.delete();
    m_e0 = 1'b0;
    m_brk = 1'b0;
    m_sc = 8'h00;
    repeat (cycles) @(posedge clk);
    #1;
    chk("rst_outputs", {12'd0, key_valid, key_e0, key_break, frame_err, overflow, key_code, scanCode_E0}, 32'd0);
    clrn = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n;
    logic [7:0] codes [9];
    codes = '{8'h15, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E};
    do_reset(4);
    repeat (3) @(posedge clk);
    #1;

    // Plain make, latency, then break.
    send_frame(8'h1C, 1'b0, lat);
    chk("latency", lat, 32'd4);
    chk("make_1c", {22'd0, key_e0, key_break, key_code}, 32'h01C);
    send(8'hF0);
    send(8'h1C);
    settle_check("t1");
    pop_one();
    chk("break_1c", {22'd0, key_e0, key_break, key_code}, 32'h11C);
    chk("t1_sc", {24'd0, scanCode_E0}, 32'h00);
    drain(n);

    // Extended make / break.
    send(8'hE0);
    send(8'h75);
    chk("e0_make_sc", {24'd0, scanCode_E0}, 32'h75);
    chk("e0_make_head", {22'd0, key_e0, key_break, key_code}, 32'h275);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    chk("e0_break_sc", {24'd0, scanCode_E0}, 32'h00);
    settle_check("t2");
    drain(n);

    // Bad parity keeps the E0 prefix and emits nothing.
    send(8'hE0);
    send_frame(8'h1C, 1'b1, lat);
    chk("ferr_count", seen_ferr, 32'd1);
    chk("ferr_no_event", {31'd0, key_valid}, 32'd0);
    send(8'h75);
    chk("prefix_kept", {22'd0, key_e0, key_break, key_code}, 32'h275);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    settle_check("t3");
    drain(n);

    // Overflow: DEPTH+1 makes with no reads.
    for (int i = 0; i < DEPTH + 1; i++) send(codes[i]);
    chk("ovf_count", seen_ovf, 32'd1);
    chk("ovf_head", {22'd0, key_e0, key_break, key_code}, 32'h015);
    settle_check("t4");
    for (int i = 0; i < DEPTH - 1; i++) pop_one();
    chk("ovf_last", {22'd0, key_e0, key_break, key_code}, 32'h03D);
    pop_one();
    chk("ovf_empty", {31'd0, key_valid}, 32'd0);
    chk("ovf_model", mq.size(), 32'd0);

    // Partial frame abandoned by timeout.
    send_partial(8'h29, 6);
    repeat (TO + 20) @(posedge clk);
    #1;
    send(8'h29);
    chk("to_head", {22'd0, key_e0, key_break, key_code}, 32'h029);
    chk("to_no_ferr", seen_ferr, 32'd1);
    settle_check("t5");
    drain(n);
    chk("to_single", n, 32'd1);

    // Reset mid-prefix and mid-frame.
    send(8'hE0);
    send_partial(8'h75, 5);
    do_reset(3);
    repeat (4) @(posedge clk);
    #1;
    send(8'h75);
    chk("rst_head", {22'd0, key_e0, key_break, key_code}, 32'h075);
    chk("rst_sc", {24'd0, scanCode_E0}, 32'h00);
    settle_check("t6");
    drain(n);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
